// File: rtl/branch_resolve_unit.sv
// Carries BTB predictions from IF to MEM and resolves them against the real outcome.
// Drives next-PC select, flush, BTB update operands and saturating branch statistics.
module branch_resolve_unit #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    input  logic                      IF_btb_hit_i,
    input  logic [31:0]               IF_btb_rd_target_i,
    input  logic [31:0]               EXMEM_pc_i,
    input  logic                      EXMEM_is_jmp_i,
    input  logic                      EXMEM_br_taken_i,
    input  logic [31:0]               EXMEM_br_target_i,
    output logic [1:0]                pc_sel_o,
    output logic [31:0]               redirect_pc_o,
    output logic                      flush_o,
    output logic                      EXMEM_btb_hit_o,
    output logic                      EXMEM_is_jmp_o,
    output logic [INDEX_WIDTH-1:0]    EXMEM_btb_wr_index_o,
    output logic [32-INDEX_WIDTH-3:0] EXMEM_btb_wr_tag_o,
    output logic [31:0]               EXMEM_btb_wr_target_o,
    output logic [31:0]               branch_cnt_o,
    output logic [31:0]               mispredict_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [31:0] target;
    } meta_t;

    meta_t id_q;
    meta_t ex_q;
    meta_t mem_q;

    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    logic        mispredict;
    logic        use_br_target;
    logic [31:0] pc_plus4;
    logic        advance;

    assign pc_plus4 = EXMEM_pc_i + 32'd4;
    assign advance  = ~stall_i;

    always_comb begin
        mispredict    = 1'b0;
        use_br_target = 1'b0;
        if (mem_q.valid) begin
            unique case (1'b1)
                mem_q.hit & EXMEM_is_jmp_i & EXMEM_br_taken_i: begin
                    mispredict    = (mem_q.target != EXMEM_br_target_i);
                    use_br_target = 1'b1;
                end
                mem_q.hit & ~(EXMEM_is_jmp_i & EXMEM_br_taken_i): begin
                    mispredict = 1'b1;
                end
                ~mem_q.hit & EXMEM_is_jmp_i & EXMEM_br_taken_i: begin
                    mispredict    = 1'b1;
                    use_br_target = 1'b1;
                end
                default: begin
                    mispredict = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_sel_o      = {IF_btb_hit_i, 1'b0};
        redirect_pc_o = 32'd0;
        if (mispredict) begin
            pc_sel_o      = {use_br_target, 1'b1};
            redirect_pc_o = use_br_target ? EXMEM_br_target_i : pc_plus4;
        end
    end

    assign flush_o               = mispredict & ~stall_i;
    assign EXMEM_btb_hit_o       = mem_q.valid & mem_q.hit;
    assign EXMEM_is_jmp_o        = mem_q.valid & EXMEM_is_jmp_i;
    assign EXMEM_btb_wr_index_o  = EXMEM_pc_i[INDEX_WIDTH+1:2];
    assign EXMEM_btb_wr_tag_o    = EXMEM_pc_i[31:INDEX_WIDTH+2];
    assign EXMEM_btb_wr_target_o = EXMEM_br_target_i;
    assign branch_cnt_o          = branch_cnt_q;
    assign mispredict_cnt_o      = mispredict_cnt_q;

    // A flush turns the three younger slots into bubbles; the MEM op retires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q  <= '0;
            ex_q  <= '0;
            mem_q <= '0;
        end else if (advance) begin
            if (flush_o) begin
                id_q  <= '0;
                ex_q  <= '0;
                mem_q <= '0;
            end else begin
                id_q  <= '{valid: 1'b1, hit: IF_btb_hit_i,
                           target: IF_btb_rd_target_i};
                ex_q  <= id_q;
                mem_q <= ex_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q     <= 32'd0;
            mispredict_cnt_q <= 32'd0;
        end else if (advance && mem_q.valid) begin
            if (EXMEM_is_jmp_i && branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict && mispredict_cnt_q != 32'hFFFF_FFFF) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: per-cycle reference model
// plus hand-computed literal checks.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_ni;
    logic        stall_i;
    logic        if_hit;
    logic [31:0] if_tgt;
    logic [31:0] mem_pc;
    logic        mem_jmp;
    logic        mem_taken;
    logic [31:0] mem_tgt;
    logic [1:0]  pc_sel;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        btb_hit_o;
    logic        is_jmp_o;
    logic [5:0]  wr_index;
    logic [23:0] wr_tag;
    logic [31:0] wr_target;
    logic [31:0] br_cnt;
    logic [31:0] mp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(.INDEX_WIDTH(6)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .stall_i               (stall_i),
        .IF_btb_hit_i          (if_hit),
        .IF_btb_rd_target_i    (if_tgt),
        .EXMEM_pc_i            (mem_pc),
        .EXMEM_is_jmp_i        (mem_jmp),
        .EXMEM_br_taken_i      (mem_taken),
        .EXMEM_br_target_i     (mem_tgt),
        .pc_sel_o              (pc_sel),
        .redirect_pc_o         (redirect_pc),
        .flush_o               (flush),
        .EXMEM_btb_hit_o       (btb_hit_o),
        .EXMEM_is_jmp_o        (is_jmp_o),
        .EXMEM_btb_wr_index_o  (wr_index),
        .EXMEM_btb_wr_tag_o    (wr_tag),
        .EXMEM_btb_wr_target_o (wr_target),
        .branch_cnt_o          (br_cnt),
        .mispredict_cnt_o      (mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot 1 = ID, slot 3 = MEM.
    logic        m_v [1:3];
    logic        m_h [1:3];
    logic [31:0] m_t [1:3];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    initial begin
        for (int i = 1; i <= 3; i++) begin
            m_v[i] = 1'b0;
            m_h[i] = 1'b0;
            m_t[i] = 32'd0;
        end
        m_br = 32'd0;
        m_mp = 32'd0;
    end

    // A prediction is right only when it says taken-to-X and the branch went taken-to-X,
    // or it said nothing and the branch fell through (or was no branch).
    function automatic void resolve(output logic misp, output logic [1:0] sel,
                                    output logic [31:0] red);
        logic went;
        went = mem_jmp && mem_taken;
        misp = 1'b0;
        sel  = {if_hit, 1'b0};
        red  = 32'd0;
        if (m_v[3]) begin
            if (went) misp = !(m_h[3] && m_t[3] == mem_tgt);
            else      misp = m_h[3];
        end
        if (misp) begin
            sel = went ? 2'b11 : 2'b01;
            red = went ? mem_tgt : mem_pc + 32'd4;
        end
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        logic        misp;
        logic [1:0]  sel;
        logic [31:0] red;
        if (!rst_ni) begin
            for (int i = 1; i <= 3; i++) m_v[i] = 1'b0;
            m_br = 32'd0;
            m_mp = 32'd0;
        end else if (!stall_i) begin
            resolve(misp, sel, red);
            if (m_v[3] && mem_jmp && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (m_v[3] && misp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
            if (misp) begin
                for (int i = 1; i <= 3; i++) m_v[i] = 1'b0;
            end else begin
                for (int i = 3; i >= 2; i--) begin
                    m_v[i] = m_v[i-1];
                    m_h[i] = m_h[i-1];
                    m_t[i] = m_t[i-1];
                end
                m_v[1] = 1'b1;
                m_h[1] = if_hit;
                m_t[1] = if_tgt;
            end
        end
    end

    always @(negedge clk) begin
        logic        misp;
        logic [1:0]  sel;
        logic [31:0] red;
        resolve(misp, sel, red);
        chk("m_pc_sel", {30'd0, pc_sel}, {30'd0, sel});
        chk("m_redirect", redirect_pc, red);
        chk("m_flush", {31'd0, flush}, {31'd0, misp & ~stall_i});
        chk("m_btb_hit", {31'd0, btb_hit_o}, {31'd0, m_v[3] & m_h[3]});
        chk("m_is_jmp", {31'd0, is_jmp_o}, {31'd0, m_v[3] & mem_jmp});
        chk("m_index", {26'd0, wr_index}, {26'd0, mem_pc[7:2]});
        chk("m_tag", {8'd0, wr_tag}, {8'd0, mem_pc[31:8]});
        chk("m_wr_target", wr_target, mem_tgt);
        chk("m_br_cnt", br_cnt, m_br);
        chk("m_mp_cnt", mp_cnt, m_mp);
    end

    task automatic clear_mem();
        mem_jmp   = 1'b0;
        mem_taken = 1'b0;
        mem_pc    = 32'd0;
        mem_tgt   = 32'd0;
    endtask

    // Fetch one op with the given prediction, walk it to MEM, then apply its outcome.
    task automatic run_instr(input logic h, input logic [31:0] ptgt,
                             input logic j, input logic t,
                             input logic [31:0] pc, input logic [31:0] tgt);
        if_hit = h;
        if_tgt = ptgt;
        @(posedge clk);
        #1;
        if_hit = 1'b0;
        if_tgt = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        mem_jmp   = j;
        mem_taken = t;
        mem_pc    = pc;
        mem_tgt   = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_mem();
        #1;
    endtask

    initial begin
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        if_hit  = 1'b1;
        if_tgt  = 32'h0000_1234;
        clear_mem();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc_sel", {30'd0, pc_sel}, 32'd2);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_mp_cnt", mp_cnt, 32'd0);
        rst_ni = 1'b1;
        if_hit = 1'b0;
        if_tgt = 32'd0;

        run_instr(1'b0, 32'd0, 1'b0, 1'b0, 32'h0000_0010, 32'd0);
        chk("nb_pc_sel", {30'd0, pc_sel}, 32'd0);
        chk("nb_flush", {31'd0, flush}, 32'd0);
        chk("nb_br_cnt", br_cnt, 32'd0);
        chk("nb_mp_cnt", mp_cnt, 32'd0);
        tick();

        run_instr(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0080);
        chk("miss_pc_sel", {30'd0, pc_sel}, 32'd3);
        chk("miss_redirect", redirect_pc, 32'h0000_0080);
        chk("miss_flush", {31'd0, flush}, 32'd1);
        chk("miss_index", {26'd0, wr_index}, 32'h0000_0000);
        chk("miss_tag", {8'd0, wr_tag}, 32'h0000_0001);
        tick();
        chk("miss_br_cnt", br_cnt, 32'd1);
        chk("miss_mp_cnt", mp_cnt, 32'd1);
        mem_jmp = 1'b1;
        #1;
        chk("miss_bubble", {31'd0, is_jmp_o}, 32'd0);
        mem_jmp = 1'b0;

        run_instr(1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0080);
        chk("nt_pc_sel", {30'd0, pc_sel}, 32'd1);
        chk("nt_redirect", redirect_pc, 32'h0000_0104);
        chk("nt_flush", {31'd0, flush}, 32'd1);
        tick();

        run_instr(1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0090);
        chk("alias_pc_sel", {30'd0, pc_sel}, 32'd3);
        chk("alias_redirect", redirect_pc, 32'h0000_0090);
        tick();
        chk("alias_br_cnt", br_cnt, 32'd3);
        chk("alias_mp_cnt", mp_cnt, 32'd3);

        run_instr(1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0080);
        chk("ok_pc_sel", {30'd0, pc_sel}, 32'd0);
        chk("ok_flush", {31'd0, flush}, 32'd0);
        chk("ok_hit_o", {31'd0, btb_hit_o}, 32'd1);
        tick();
        chk("ok_br_cnt", br_cnt, 32'd4);
        chk("ok_mp_cnt", mp_cnt, 32'd3);

        run_instr(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0040);
        stall_i = 1'b1;
        #1;
        chk("stall_flush", {31'd0, flush}, 32'd0);
        chk("stall_pc_sel", {30'd0, pc_sel}, 32'd3);
        chk("stall_redirect", redirect_pc, 32'h0000_0040);
        repeat (2) @(posedge clk);
        #2;
        chk("stall_br_cnt", br_cnt, 32'd4);
        chk("stall_mp_cnt", mp_cnt, 32'd3);
        chk("stall_flush2", {31'd0, flush}, 32'd0);
        stall_i = 1'b0;
        #1;
        chk("release_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("release_br_cnt", br_cnt, 32'd5);
        chk("release_mp_cnt", mp_cnt, 32'd4);
        chk("release_flush_off", {31'd0, flush}, 32'd0);

        dut.branch_cnt_q     = 32'hFFFF_FFFF;
        dut.mispredict_cnt_q = 32'hFFFF_FFFF;
        m_br = 32'hFFFF_FFFF;
        m_mp = 32'hFFFF_FFFF;
        run_instr(1'b1, 32'h0000_0800, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0800);
        chk("wrap_pc_sel", {30'd0, pc_sel}, 32'd1);
        chk("wrap_redirect", redirect_pc, 32'h0000_0000);
        chk("wrap_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("sat_br_cnt", br_cnt, 32'hFFFF_FFFF);
        chk("sat_mp_cnt", mp_cnt, 32'hFFFF_FFFF);

        run_instr(1'b1, 32'h0000_0500, 1'b0, 1'b0, 32'h0000_0300, 32'd0);
        chk("stale_pc_sel", {30'd0, pc_sel}, 32'd1);
        chk("stale_redirect", redirect_pc, 32'h0000_0304);
        tick();

        run_instr(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0010);
        rst_ni = 1'b0;
        #1;
        chk("arst_br_cnt", br_cnt, 32'd0);
        chk("arst_mp_cnt", mp_cnt, 32'd0);
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_redirect", redirect_pc, 32'd0);
        chk("arst_is_jmp", {31'd0, is_jmp_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        clear_mem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
